buf_bank_burst: RTL

Parametrised banked buffer controller that moves bursts of words between a streaming port and `NBANK` parallel single-port SRAM banks. A configuration handshake sets the burst start address, length and direction. The controller then generates addresses with wrap-around and presents read data through a 2-entry output FIFO, so reads sustain one word per cycle under backpressure. It is the next-generation Input/Weight/GB buffer front end: one instance per buffer, feeding or fed by the PE array and DMA.

---
 rtl/buf_bank_burst_pkg.sv | 19 +
 rtl/buf_out_fifo2.sv | 66 ++++++
 rtl/sram_sp.sv | 33 +++
 rtl/buf_bank_burst.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/buf_bank_burst_pkg.sv
// rtl/buf_bank_burst_pkg.sv - shared types and constants for the banked burst buffer
package buf_bank_burst_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } SP_rwmode;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } BufBurst_state;

  localparam int unsigned BUF_FIFO_DEPTH = 2;
  localparam int unsigned BUF_FIFO_CNT_W = $clog2(BUF_FIFO_DEPTH + 1);

endpackage

// File: rtl/buf_out_fifo2.sv
// rtl/buf_out_fifo2.sv - two-entry rdy/ack output FIFO; entry 0 is always the head
module buf_out_fifo2
  import buf_bank_burst_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  output logic                      o_rdy,
  input  logic                      i_ack,
  output logic [W-1:0]              o_data,
  output logic [BUF_FIFO_CNT_W-1:0] fifo_cnt
);

  logic [W-1:0]              ent0_q, ent0_d;
  logic [W-1:0]              ent1_q, ent1_d;
  logic [BUF_FIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic                      pop;

  assign o_rdy    = (cnt_q != '0);
  assign pop      = o_rdy && i_ack;
  assign o_data   = ent0_q;
  assign fifo_cnt = cnt_q;

  // The head only moves on a pop or a push into an empty FIFO, so it is stable under backpressure.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == '0) ent0_d = push_data;
        else             ent1_d = push_data;
        cnt_d = cnt_q + BUF_FIFO_CNT_W'(1);
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - BUF_FIFO_CNT_W'(1);
      end
      2'b11: begin
        if (cnt_q == BUF_FIFO_CNT_W'(1)) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_sp.sv
// rtl/sram_sp.sv - single-port SRAM bank, one-cycle registered read
module SRAM_SP
  import buf_bank_burst_pkg::*;
#(
  parameter  int DWD   = 16,
  parameter  int DEPTH = 256,
  localparam int AWD   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           ce,
  input  SP_rwmode       rw,
  input  logic [AWD-1:0] addr,
  input  logic [DWD-1:0] wdata,
  output logic [DWD-1:0] rdata
);

  logic [DWD-1:0] mem_q [DEPTH];
  logic [DWD-1:0] rdata_q;

  // Array contents are not reset; only the control path is.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (rw == WRITE) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/buf_bank_burst.sv
// rtl/buf_bank_burst.sv - burst controller moving beats between a stream port and NBANK SRAM banks
module buf_bank_burst
  import buf_bank_burst_pkg::*;
#(
  parameter  int NBANK = 4,
  parameter  int DWD   = 16,
  parameter  int DEPTH = 256,
  localparam int AWD   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_rdy,
  output logic           cfg_ack,
  input  logic [AWD-1:0] i_cfg_base,
  input  logic [AWD:0]   i_cfg_len,
  input  SP_rwmode       i_cfg_mode,
  input  logic           w_rdy,
  output logic           w_ack,
  input  logic [DWD-1:0] i_wdata [NBANK],
  output logic           r_rdy,
  input  logic           r_ack,
  output logic [DWD-1:0] o_rdata [NBANK],
  output logic           o_busy,
  output logic           o_done
);

  BufBurst_state             state_q, state_d;
  logic [AWD-1:0]            addr_q, addr_d;
  logic [AWD:0]              remain_q, remain_d;
  logic                      inflight_q, inflight_d;
  logic                      done_q, done_d;

  logic                      wr_fire, issue, pop;
  logic                      sram_ce;
  SP_rwmode                  sram_rw;
  logic [BUF_FIFO_CNT_W-1:0] fifo_cnt;
  logic [2:0]                occ, occ_lim;
  logic [NBANK*DWD-1:0]      push_data, fifo_head;
  logic [DWD-1:0]            bank_rdata [NBANK];

  assign pop     = r_rdy && r_ack;
  // Entries held plus the one in flight must leave room once this cycle's pop is taken.
  assign occ     = 3'(fifo_cnt) + 3'(inflight_q);
  assign occ_lim = 3'(BUF_FIFO_DEPTH) + 3'(pop);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    remain_d = remain_q;
    done_d  = 1'b0;
    cfg_ack = 1'b0;
    w_ack   = 1'b0;
    wr_fire = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ack = 1'b1;
        if (cfg_rdy) begin
          addr_d   = i_cfg_base;
          remain_d = i_cfg_len;
          if (i_cfg_len == '0) done_d  = 1'b1;
          else                 state_d = (i_cfg_mode == WRITE) ? WR : RD;
        end
      end
      WR: begin
        w_ack = 1'b1;
        if (w_rdy) begin
          wr_fire  = 1'b1;
          addr_d   = addr_q + AWD'(1);
          remain_d = remain_q - (AWD+1)'(1);
          if (remain_q == (AWD+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        if (remain_q != '0 && occ < occ_lim) begin
          issue    = 1'b1;
          addr_d   = addr_q + AWD'(1);
          remain_d = remain_q - (AWD+1)'(1);
          if (remain_q == (AWD+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_cnt == '0 || (fifo_cnt == BUF_FIFO_CNT_W'(1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  assign sram_ce = wr_fire || issue;
  assign sram_rw = wr_fire ? WRITE : READ;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    SRAM_SP #(
      .DWD   (DWD),
      .DEPTH (DEPTH)
    ) u_sram (
      .clk   (clk),
      .ce    (sram_ce),
      .rw    (sram_rw),
      .addr  (addr_q),
      .wdata (i_wdata[b]),
      .rdata (bank_rdata[b])
    );
    assign push_data[b*DWD +: DWD] = bank_rdata[b];
    assign o_rdata[b]              = fifo_head[b*DWD +: DWD];
  end

  buf_out_fifo2 #(
    .W (NBANK*DWD)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_data),
    .o_rdy     (r_rdy),
    .i_ack     (r_ack),
    .o_data    (fifo_head),
    .fifo_cnt  (fifo_cnt)
  );

endmodule
